// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Provides a zero-latency next-PC prediction for the fetch stage, resolves
// branches reported by the execute stage (mispredict + redirect PC), trains
// the table on each resolved branch and keeps saturating debug counters.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] f_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_npc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic [XLEN-1:0] upd_pred_npc,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            clr_stats,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_miss
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic [XLEN-1:0]  actual_npc;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[XLEN-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[XLEN-1:IDX_W+2];

    // Fetch-side lookup: predict taken only on a tag hit with a strong/weak-taken counter
    always_comb begin
        f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken = f_hit && ctr_q[f_idx][1];
        pred_npc   = pred_taken ? target_q[f_idx] : (f_pc + PC_STEP);
    end

    // Execute-side resolution: compare the true next PC with what was predicted
    always_comb begin
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        actual_npc  = upd_taken ? upd_target : (upd_pc + PC_STEP);
        redirect_pc = actual_npc;
        mispredict  = upd_valid && (upd_pred_npc != actual_npc);
    end

    // Table training: adjust counters on hits, allocate on taken misses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    if (ctr_q[u_idx] != 2'b11) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                    end
                    target_q[u_idx] <= upd_target;
                end else if (ctr_q[u_idx] != 2'b00) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_idx]    <= 2'b10;
            end
        end
    end

    // Saturating debug counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_branch <= '0;
            cnt_miss   <= '0;
        end else if (clr_stats) begin
            cnt_branch <= '0;
            cnt_miss   <= '0;
        end else begin
            if (upd_valid && (cnt_branch != '1)) begin
                cnt_branch <= cnt_branch + 1'b1;
            end
            if (mispredict && (cnt_miss != '1)) begin
                cnt_miss <= cnt_miss + 1'b1;
            end
        end
    end

endmodule
